vga_draw_arbiter: RTL and testbench

Owns the single VGA adapter write port and shares it between up to NUM_REQ animated objects, such as the scrolling image and the player sprite. Each requester asks for its box to be moved to a new position. For each granted request the block:
- erases the box at the requester's previously drawn position, using BG_COLOUR,
- draws the box at the new position,
- pulses done.
Requesters are served round-robin, one at a time, at one pixel per clock.

---
 rtl/vga_draw_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// Shares the single VGA adapter write port between NUM_REQ box-moving requesters.
// Each granted move erases the box at its last drawn position, draws it at the new one, then pulses done.
//
// state | meaning
// IDLE  | waiting for a request; round-robin pick on the next edge
// ERASE | scanning the old box with BG_COLOUR
// DRAW  | scanning the new box with the latched colour
// DONE  | one-cycle done pulse on the granted index
module vga_draw_arbiter #(
  parameter int         NUM_REQ   = 2,
  parameter int         BOX_W     = 8,
  parameter int         BOX_H     = 8,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ERASE = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0]    CX_LAST = 4'(BOX_W - 1);
  localparam logic [3:0]    CY_LAST = 4'(BOX_H - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  logic [1:0]    state;
  logic [IW-1:0] rr;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic          found;
  int            idx;
  logic [3:0]    cx;
  logic [3:0]    cy;

  logic [7:0]    new_x;
  logic [6:0]    new_y;
  logic [2:0]    new_colour;

  logic [7:0]    old_x [NUM_REQ];
  logic [6:0]    old_y [NUM_REQ];
  logic [NUM_REQ-1:0] valid;

  logic [7:0]    in_x      [NUM_REQ];
  logic [6:0]    in_y      [NUM_REQ];
  logic [2:0]    in_colour [NUM_REQ];

  logic          scanning;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [8:0]    sum_x;
  logic [7:0]    sum_y;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign in_x[g]      = req_x[8*g +: 8];
    assign in_y[g]      = req_y[7*g +: 7];
    assign in_colour[g] = req_colour[3*g +: 3];
  end

  // First set request at or above rr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign scanning = (state == ERASE) || (state == DRAW);
  assign base_x   = (state == ERASE) ? old_x[sel] : new_x;
  assign base_y   = (state == ERASE) ? old_y[sel] : new_y;
  assign sum_x    = {1'b0, base_x} + {5'd0, cx};
  assign sum_y    = {1'b0, base_y} + {4'd0, cy};

  // Off-screen pixels still take their cycle; only the write enable is suppressed.
  assign vga_plot   = scanning && (sum_x < 9'd160) && (sum_y < 8'd120);
  assign vga_x      = scanning ? sum_x[7:0] : 8'd0;
  assign vga_y      = scanning ? sum_y[6:0] : 7'd0;
  assign vga_colour = (state == ERASE) ? BG_COLOUR :
                      (state == DRAW)  ? new_colour : 3'd0;

  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      rr         <= '0;
      sel        <= '0;
      grant      <= '0;
      valid      <= '0;
      cx         <= '0;
      cy         <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_colour <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        old_x[i] <= '0;
        old_y[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel        <= pick;
            grant      <= NUM_REQ'(1) << pick;
            new_x      <= in_x[pick];
            new_y      <= in_y[pick];
            new_colour <= in_colour[pick];
            cx         <= '0;
            cy         <= '0;
            state      <= valid[pick] ? ERASE : DRAW;
          end
        end
        ERASE, DRAW: begin
          if (cx == CX_LAST) begin
            cx <= '0;
            if (cy == CY_LAST) begin
              cy <= '0;
              if (state == ERASE) begin
                state <= DRAW;
              end else begin
                old_x[sel] <= new_x;
                old_y[sel] <= new_y;
                valid[sel] <= 1'b1;
                state      <= DONE;
              end
            end else begin
              cy <= cy + 4'd1;
            end
          end else begin
            cx <= cx + 4'd1;
          end
        end
        DONE: begin
          grant <= '0;
          rr    <= (sel == IDX_LAST) ? '0 : sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: table of box moves checked pixel by pixel,
// plus sequences for reset, round-robin ordering and reset during a draw.
module tb_vga_draw_arbiter;

  localparam int BOX_W = 8;
  localparam int BOX_H = 8;

  logic        clk;
  logic        resetn;
  logic [1:0]  req;
  logic [15:0] req_x;
  logic [13:0] req_y;
  logic [5:0]  req_colour;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int passed = 0;
  int total  = 0;

  vga_draw_arbiter #(.NUM_REQ(2), .BOX_W(BOX_W), .BOX_H(BOX_H), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mask;
    int idx;
    int x, y, c;
    bit erase;
    int ox, oy;
    bit chg;
    int plots;
    int done_at;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slice(input int idx, input int x, input int y, input int c);
    for (int i = 0; i < 2; i++) begin
      req_x[8*i +: 8]      = (i == idx) ? 8'(x) : 8'(x ^ 'h5A);
      req_y[7*i +: 7]      = (i == idx) ? 7'(y) : 7'(y ^ 'h2B);
      req_colour[3*i +: 3] = (i == idx) ? 3'(c) : 3'(~c);
    end
  endtask

  // Caller is in cycle E0+1; returns the cycle number (from E0) of the done pulse, 0 on timeout.
  task automatic wait_done(output int cyc, output logic [1:0] d);
    cyc = 0;
    d   = 2'b00;
    for (int n = 1; n <= 300; n++) begin
      if (done != 2'b00) begin
        cyc = n;
        d   = done;
        break;
      end
      step();
    end
  endtask

  task automatic run_move(input vec_t v);
    int np, done_at, bad, gbad, plots, k, ex, ey, ec;
    bit has_px, ep;
    np = BOX_W * BOX_H;
    done_at = 0; bad = 0; gbad = 0; plots = 0;
    k = 0; ex = 0; ey = 0; ec = 0;
    drive_slice(v.idx, v.x, v.y, v.c);
    req = v.mask;
    step();
    if (v.chg) begin
      req_x      = ~req_x;
      req_y      = ~req_y;
      req_colour = ~req_colour;
    end
    for (int n = 1; n <= 200; n++) begin
      has_px = 1'b0;
      if (v.erase && n <= np) begin
        has_px = 1'b1; k = n - 1;
        ex = v.ox + k % BOX_W; ey = v.oy + k / BOX_W; ec = 0;
      end else if (v.erase && n <= 2*np) begin
        has_px = 1'b1; k = n - np - 1;
        ex = v.x + k % BOX_W; ey = v.y + k / BOX_W; ec = v.c;
      end else if (!v.erase && n <= np) begin
        has_px = 1'b1; k = n - 1;
        ex = v.x + k % BOX_W; ey = v.y + k / BOX_W; ec = v.c;
      end
      ep = has_px && (ex < 160) && (ey < 120);
      if (vga_plot === 1'b1) plots++;
      if (vga_plot !== ep) bad++;
      else if (ep && (vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'(ec))) bad++;
      if (grant !== 2'(1 << v.idx) || busy !== 1'b1) gbad++;
      if (done !== 2'b00) begin
        if (done === 2'(1 << v.idx)) done_at = n;
        else bad++;
        break;
      end
      step();
    end
    req = 2'b00;
    step();
    chk("pixels", bad, 0);
    chk("plot_count", plots, v.plots);
    chk("done_cycle", done_at, v.done_at);
    chk("grant_busy_stable", gbad, 0);
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int cyc, cnt;
    logic [1:0] d;

    //          mask   idx x    y    c  erase ox   oy   chg plots done
    vecs[0] = '{2'b01, 0, 10,  20,  4, 1'b0,  0,   0,  1'b0, 64,  65};
    vecs[1] = '{2'b01, 0, 9,   20,  4, 1'b1,  10,  20, 1'b0, 128, 129};
    vecs[2] = '{2'b10, 1, 156, 116, 2, 1'b0,  0,   0,  1'b0, 16,  65};
    vecs[3] = '{2'b10, 1, 156, 116, 2, 1'b1,  156, 116, 1'b0, 32, 129};
    vecs[4] = '{2'b01, 0, 150, 0,   7, 1'b1,  9,   20, 1'b1, 128, 129};

    resetn = 1'b0; req = 2'b00; req_x = '0; req_y = '0; req_colour = '0;
    repeat (3) step();
    chk("reset_outputs", int'({grant, done, busy, vga_x, vga_y, vga_colour, vga_plot}), 0);
    resetn = 1'b1;
    step();
    chk("idle_no_req", int'({grant, busy, vga_plot}), 0);

    // Simultaneous requests: 0 first, then 1, then 0 again.
    req_x = {8'd40, 8'd20}; req_y = {7'd50, 7'd30}; req_colour = {3'd2, 3'd1};
    req = 2'b11;
    step();
    chk("rr_first_grant", int'(grant), 1);
    wait_done(cyc, d);
    chk("rr_done0_cycle", cyc, 65);
    chk("rr_done0_index", int'(d), 1);
    step();
    chk("rr_idle_gap", int'(busy), 0);
    step();
    chk("rr_second_grant", int'(grant), 2);
    wait_done(cyc, d);
    chk("rr_done1_index", int'(d), 2);
    req = 2'b01;
    step();
    step();
    chk("rr_third_grant", int'(grant), 1);
    wait_done(cyc, d);
    chk("rr_done0_erase_cycle", cyc, 129);
    req = 2'b00;
    step();

    // Reset in the middle of DRAW for requester 0 (valid, so erase precedes draw).
    drive_slice(0, 60, 40, 5);
    req = 2'b01;
    step();
    repeat (79) step();
    chk("mid_draw_plot", int'(vga_plot), 1);
    chk("mid_draw_x", int'(vga_x), 67);
    chk("mid_draw_y", int'(vga_y), 41);
    chk("mid_draw_colour", int'(vga_colour), 5);
    resetn = 1'b0; req = 2'b00;
    step();
    chk("abort_idle", int'({busy, vga_plot, grant, done}), 0);
    resetn = 1'b1;
    cnt = 0;
    for (int n = 0; n < 70; n++) begin
      if (done !== 2'b00 || busy !== 1'b0) cnt++;
      step();
    end
    chk("abort_no_done", cnt, 0);

    for (int i = 0; i < 5; i++) run_move(vecs[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
